rd_desc_sched: RTL

//  Round-robin scheduler that shares one packet reader (rd_ctrl) among N_REQ descriptor sources.
//  - Accepts one descriptor (control, addr, len) per transaction via valid/ready.
//  - Validates the length, then issues a one-cycle start pulse to the reader with registered operands.
//  - Waits for the reader's done indication, guarded by a watchdog timeout.
//  - Returns a completion record (source id + status) to the host-side status logic.

---
 rtl/rd_desc_sched.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/rd_desc_sched.sv
// rd_desc_sched
//   Round-robin scheduler that lets N_REQ descriptor sources share one packet
//   reader. One descriptor (ctrl, addr, len) is accepted per transaction. Its
//   length is checked, the reader gets a one-cycle start pulse with registered
//   operands, and the scheduler waits for rd_done under a watchdog. It then
//   returns a completion record (source id + status) to the status logic.
//
// Ports
//   clk, reset         clock; synchronous active-low reset
//   enable             1 = new grants allowed
//   req_valid/ready    per-source handshake; req_ready is one-hot or zero
//   req_ctrl/addr/len  packed per-source descriptor fields, source i at [32*i +: 32]
//   rd_start           one-cycle start pulse to the reader
//   rd_control/pkt_*   operands latched at accept
//   rd_abort           one-cycle pulse when the watchdog expires
//   rd_done            reader finished; sampled only while waiting
//   cmpl_valid/ready   completion handshake
//   cmpl_id/status     completion record (00 ok, 01 timeout, 10 bad length)
//   busy               scheduler is not idle
//   pkt_cnt            number of successful completions (wraps)
module rd_desc_sched #(
    parameter int N_REQ       = 4,
    parameter int MAX_LEN     = 1518,
    parameter int TIMEOUT_CYC = 65535,
    parameter int IDW         = $clog2(N_REQ)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [32*N_REQ-1:0]  req_ctrl,
    input  logic [32*N_REQ-1:0]  req_addr,
    input  logic [32*N_REQ-1:0]  req_len,
    output logic                 rd_start,
    output logic [31:0]          rd_control,
    output logic [31:0]          rd_pkt_addr,
    output logic [31:0]          rd_pkt_len,
    output logic                 rd_abort,
    input  logic                 rd_done,
    output logic                 cmpl_valid,
    output logic [IDW-1:0]       cmpl_id,
    output logic [1:0]           cmpl_status,
    input  logic                 cmpl_ready,
    output logic                 busy,
    output logic [31:0]          pkt_cnt
);

    // Watchdog counter wide enough to hold TIMEOUT_CYC-1.
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    localparam logic [1:0] ST_OK  = 2'b00;
    localparam logic [1:0] ST_TMO = 2'b01;
    localparam logic [1:0] ST_LEN = 2'b10;

    typedef enum logic [1:0] {IDLE, START, WAIT, CMPL} state_t;

    state_t          state;
    logic [IDW-1:0]  last;
    logic [IDW-1:0]  winner;
    logic [IDW-1:0]  rr_idx;
    logic            any_valid;
    logic            accept;
    logic [TW-1:0]   tcnt;
    logic [31:0]     win_ctrl;
    logic [31:0]     win_addr;
    logic [31:0]     win_len;

    function automatic logic len_ok(input logic [31:0] len);
        return (len != 32'd0) && (len <= 32'(MAX_LEN));
    endfunction

    // Search starts just after the last granted source so a continuously
    // valid source never waits for more than N_REQ-1 other grants.
    always_comb begin
        any_valid = 1'b0;
        winner    = '0;
        rr_idx    = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            rr_idx = IDW'((int'(last) + k) % N_REQ);
            if (!any_valid && req_valid[rr_idx]) begin
                any_valid = 1'b1;
                winner    = rr_idx;
            end
        end
    end

    always_comb begin
        win_ctrl = '0;
        win_addr = '0;
        win_len  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (winner == IDW'(i)) begin
                win_ctrl = req_ctrl[32*i +: 32];
                win_addr = req_addr[32*i +: 32];
                win_len  = req_len[32*i +: 32];
            end
        end
    end

    assign accept = (state == IDLE) && enable && any_valid;
    assign busy   = (state != IDLE);

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[winner] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            last        <= IDW'(N_REQ - 1);
            rd_start    <= 1'b0;
            rd_abort    <= 1'b0;
            cmpl_valid  <= 1'b0;
            cmpl_id     <= '0;
            cmpl_status <= '0;
            rd_control  <= '0;
            rd_pkt_addr <= '0;
            rd_pkt_len  <= '0;
            pkt_cnt     <= '0;
            tcnt        <= '0;
        end else begin
            rd_start <= 1'b0;
            rd_abort <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        last        <= winner;
                        cmpl_id     <= winner;
                        rd_control  <= win_ctrl;
                        rd_pkt_addr <= win_addr;
                        rd_pkt_len  <= win_len;
                        if (len_ok(win_len)) begin
                            rd_start <= 1'b1;
                            state    <= START;
                        end else begin
                            // Bad length: report it without touching the reader.
                            cmpl_status <= ST_LEN;
                            cmpl_valid  <= 1'b1;
                            state       <= CMPL;
                        end
                    end
                end
                START: begin
                    tcnt  <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    // rd_done is checked first so it wins over a same-cycle timeout.
                    if (rd_done) begin
                        cmpl_status <= ST_OK;
                        cmpl_valid  <= 1'b1;
                        state       <= CMPL;
                    end else if (tcnt == TW'(TIMEOUT_CYC - 1)) begin
                        rd_abort    <= 1'b1;
                        cmpl_status <= ST_TMO;
                        cmpl_valid  <= 1'b1;
                        state       <= CMPL;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                CMPL: begin
                    if (cmpl_ready) begin
                        cmpl_valid <= 1'b0;
                        if (cmpl_status == ST_OK) begin
                            pkt_cnt <= pkt_cnt + 32'd1;
                        end
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
